// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer and the ALU it drives:
// datapath widths, LEGv8 opcode encodings, 4-bit ALU control codes and
// the sequencer FSM state type.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 11;
    localparam int CTRL_W = 4;

    // Full-width opcodes
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_EOR  = 11'b11001010000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;

    // Prefix-matched opcodes (low bits are part of the immediate/register field)
    localparam logic [7:0] OPC_CBZ_PFX  = 8'b10110100;
    localparam logic [8:0] OPC_MOVZ_PFX = 9'b110100101;

    // ALU control codes, identical to the ALU's own ALUctrl decoding
    localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_ORR   = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_EOR   = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b1010;
    localparam logic [CTRL_W-1:0] ALU_MOVZ  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EVAL  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational LEGv8 opcode to ALU control translation. The first
// matching entry wins; anything unmatched is reported as illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              legal
);

    // Priority match of the opcode against the supported instruction set
    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        if (opcode == OPC_LDUR || opcode == OPC_STUR || opcode == OPC_ADD) begin
            ctrl  = ALU_ADD;
            legal = 1'b1;
        end else if (opcode == OPC_ORR) begin
            ctrl  = ALU_ORR;
            legal = 1'b1;
        end else if (opcode == OPC_AND) begin
            ctrl  = ALU_AND;
            legal = 1'b1;
        end else if (opcode[10:3] == OPC_CBZ_PFX) begin
            ctrl  = ALU_PASSB;
            legal = 1'b1;
        end else if (opcode == OPC_EOR) begin
            ctrl  = ALU_EOR;
            legal = 1'b1;
        end else if (opcode == OPC_SUB) begin
            ctrl  = ALU_SUB;
            legal = 1'b1;
        end else if (opcode[10:2] == OPC_MOVZ_PFX) begin
            ctrl  = ALU_MOVZ;
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side sequencer for the datapath ALU. Accepts one decoded op,
// presents it to the ALU for a setup cycle with enable low, then one
// evaluate cycle with enable high, captures the result and returns it.
// Illegal opcodes skip the ALU and answer with an error response.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_err
);

    state_t              state_reg;
    state_t              state_next;
    logic [CTRL_W-1:0]   dec_ctrl;
    logic                dec_legal;
    logic [CTRL_W-1:0]   alu_ctrl_reg;
    logic [DATA_W-1:0]   alu_data1_reg;
    logic [DATA_W-1:0]   alu_data2_reg;
    logic [DATA_W-1:0]   out_result_reg;
    logic                out_zero_reg;
    logic                out_err_reg;
    logic                accept;

    alu_op_decode u_decode (
        .opcode (in_opcode),
        .ctrl   (dec_ctrl),
        .legal  (dec_legal)
    );

    // Handshake and ALU strobe are pure functions of the state register, so
    // an asynchronous reset drops alu_enable the moment rst_n falls.
    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_RESP);
    assign alu_enable = (state_reg == ST_EVAL);
    assign accept     = in_valid && in_ready;

    assign alu_ctrl   = alu_ctrl_reg;
    assign alu_data1  = alu_data1_reg;
    assign alu_data2  = alu_data2_reg;
    assign out_result = out_result_reg;
    assign out_zero   = out_zero_reg;
    assign out_err    = out_err_reg;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> SETUP -> EVAL -> RESP -> IDLE, illegal ops jump to RESP
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = dec_legal ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: state_next = ST_EVAL;
            ST_EVAL:  state_next = ST_RESP;
            ST_RESP: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // ALU-side operand/control registers and response payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl_reg   <= '0;
            alu_data1_reg  <= '0;
            alu_data2_reg  <= '0;
            out_result_reg <= '0;
            out_zero_reg   <= 1'b0;
            out_err_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && accept) begin
                if (dec_legal) begin
                    alu_ctrl_reg  <= dec_ctrl;
                    alu_data1_reg <= in_a;
                    alu_data2_reg <= in_b;
                end else begin
                    // The ALU is left alone; answer straight away with an error
                    out_result_reg <= '0;
                    out_zero_reg   <= 1'b0;
                    out_err_reg    <= 1'b1;
                end
            end
            if (state_reg == ST_EVAL) begin
                out_err_reg <= 1'b0;
                // Only the branch-compare op consumes the zero flag; for all
                // other ops the ALU zero output is not trustworthy and is masked.
                if (alu_ctrl_reg == ALU_PASSB) begin
                    out_result_reg <= '0;
                    out_zero_reg   <= alu_zero;
                end else begin
                    out_result_reg <= alu_result;
                    out_zero_reg   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU responds to the
// enable edge, and a reference model computes each op's response from the
// instruction semantics. Directed cases cover latency, stalls, the error
// path and reset during evaluation, followed by randomized traffic.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic        alu_enable;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_ctrl   (alu_ctrl),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_enable (alu_enable),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: evaluates only on a rising enable edge
    function automatic logic [31:0] alu_eval(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0010: return x + y;
            4'b0100: return x | y;
            4'b0110: return x & y;
            4'b0111: return y;
            4'b1001: return x ^ y;
            4'b1010: return x - y;
            4'b1101: return y;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        alu_result = 32'hDEAD_BEEF;
        alu_zero   = 1'b1;
    end

    always @(posedge alu_enable) begin
        alu_result <= alu_eval(alu_ctrl, alu_data1, alu_data2);
        alu_zero   <= (alu_eval(alu_ctrl, alu_data1, alu_data2) == 32'h0);
    end

    // Reference model: response expected for an instruction, from its meaning
    task automatic ref_model(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                             output logic err, output logic zero, output logic [31:0] res);
        err  = 1'b0;
        zero = 1'b0;
        res  = 32'h0;
        if (opc == 11'b11111000010 || opc == 11'b11111000000 || opc == 11'b10001011000) res = a + b;
        else if (opc == 11'b10101010000)     res = a | b;
        else if (opc == 11'b10001010000)     res = a & b;
        else if (opc[10:3] == 8'b10110100)   zero = (b == 32'h0);
        else if (opc == 11'b11001010000)     res = a ^ b;
        else if (opc == 11'b11001011000)     res = a - b;
        else if (opc[10:2] == 9'b110100101)  res = b;
        else                                 err = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Issue one op, follow it to its response and complete the handshake.
    // hold: cycles out_ready stays low in RESP; keep_valid: leave in_valid
    // asserted the whole time to prove no second accept happens.
    task automatic do_op(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit keep_valid);
        logic        e_err;
        logic        e_zero;
        logic [31:0] e_res;
        int          n;
        int          cyc;
        int          en_cnt;
        int          en_at;
        ref_model(opc, a, b, e_err, e_zero, e_res);

        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 20), 32'd1);

        in_valid  = 1'b1;
        in_opcode = opc;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        @(negedge clk);
        if (!keep_valid) begin
            in_valid  = 1'b0;
            in_opcode = 11'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
        end

        cyc    = 1;
        en_cnt = 0;
        en_at  = 0;
        while (!out_valid && cyc < 10) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            if (alu_enable) begin
                en_cnt++;
                en_at = cyc;
                check("eval_data1", alu_data1, a);
                check("eval_data2", alu_data2, b);
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), e_err ? 32'd1 : 32'd3);
        check("enable_cycles", 32'(en_cnt), e_err ? 32'd0 : 32'd1);
        if (!e_err) check("enable_slot", 32'(en_at), 32'd2);

        for (int h = 0; h <= hold; h++) begin
            check("resp_valid", 32'(out_valid), 32'd1);
            check("resp_enable", 32'(alu_enable), 32'd0);
            check("resp_in_ready", 32'(in_ready), 32'd0);
            check("resp_result", out_result, e_res);
            check("resp_zero", 32'(out_zero), 32'(e_zero));
            check("resp_err", 32'(out_err), 32'(e_err));
            if (h == hold) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_idle", 32'(in_ready), 32'd1);
        $display("op opc=%b a=%h b=%h hold=%0d -> res=%h zero=%0b err=%0b lat=%0d",
                 opc, a, b, hold, e_res, e_zero, e_err, cyc);
    endtask

    logic [10:0] rnd_opc;
    logic [31:0] rnd_a;
    logic [31:0] rnd_b;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_enable", 32'(alu_enable), 32'd0);
        check("rst_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_data1", alu_data1, 32'd0);
        check("rst_data2", alu_data2, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(11'b10001011000, 32'd5, 32'd7, 0, 1'b0);                 // ADD
        do_op(11'b11001011000, 32'd3, 32'd5, 1, 1'b1);                 // SUB, back-to-back held off
        do_op(11'b10110100101, 32'd4, 32'd0, 0, 1'b0);                 // CBZ taken
        do_op(11'b10110100011, 32'd4, 32'd9, 0, 1'b0);                 // CBZ not taken
        do_op(11'b00000000000, 32'd1, 32'd2, 0, 1'b0);                 // illegal
        do_op(11'b10101010000, 32'h0000_00F0, 32'h0000_000F, 5, 1'b0); // ORR stall
        do_op(11'b11001011000, 32'd9, 32'd9, 0, 1'b0);                 // SUB to zero, zero masked
        do_op(11'b11010010110, 32'd1, 32'h1234, 2, 1'b0);              // MOVZ

        // Reset while the ALU is enabled
        in_valid  = 1'b1;
        in_opcode = 11'b10001011000;
        in_a      = 32'd100;
        in_b      = 32'd200;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_enable", 32'(alu_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_enable", 32'(alu_enable), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(out_valid), 32'd0);
        end
        do_op(11'b10001011000, 32'd1, 32'd1, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: rnd_opc = 11'b11111000010;
                1: rnd_opc = 11'b11111000000;
                2: rnd_opc = 11'b10001011000;
                3: rnd_opc = 11'b10101010000;
                4: rnd_opc = 11'b10001010000;
                5: rnd_opc = {8'b10110100, 3'($urandom)};
                6: rnd_opc = 11'b11001010000;
                7: rnd_opc = 11'b11001011000;
                8: rnd_opc = {9'b110100101, 2'($urandom)};
                default: rnd_opc = 11'($urandom);
            endcase
            rnd_a = $urandom;
            rnd_b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            do_op(rnd_opc, rnd_a, rnd_b, $urandom_range(0, 3), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
